// File: rtl/snap_capture_ctrl.sv
// Snapshot capture sequencer: arm, wait for trigger, stream qualified samples
// into the snapshot BRAM until full or stopped, and publish done/busy/count.
module snap_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ctrl_in,
    input  logic              trig,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_we,
    output logic [31:0]       status_out
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_CNT = FULL_CNT - {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] ZERO_CNT = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state_r;
    state_t          next_state_s;
    logic [ADDR_W:0] count_r;
    logic [ADDR_W:0] count_nxt_s;
    logic            arm_q_r;
    logic            arm_rise_s;
    logic            stop_s;
    logic            hit_s;
    logic            wr_s;
    logic [31:0]     status_nxt_s;
    logic            ctrl_unused_s;

    assign arm_rise_s    = ctrl_in[0] & ~arm_q_r;
    assign stop_s        = ctrl_in[2];
    assign hit_s         = trig | ctrl_in[1];
    assign ctrl_unused_s = ^ctrl_in[31:3];

    // Next-state, write qualification and next status word.
    always_comb begin
        next_state_s = state_r;
        count_nxt_s  = count_r;
        wr_s         = 1'b0;
        status_nxt_s = 32'h0000_0000;

        // Re-arm outranks everything; a simultaneous sample is not written
        // because the address counter is being restarted on this edge.
        if (arm_rise_s) begin
            next_state_s = ST_ARMED;
            count_nxt_s  = ZERO_CNT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    next_state_s = ST_IDLE;
                end
                ST_ARMED: begin
                    if (stop_s) begin
                        next_state_s = ST_DONE;
                    end else if (hit_s) begin
                        next_state_s = ST_CAPTURE;
                        wr_s         = din_valid & (count_r != FULL_CNT);
                    end else begin
                        next_state_s = ST_ARMED;
                    end
                end
                ST_CAPTURE: begin
                    if (stop_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_CAPTURE;
                        wr_s         = din_valid & (count_r != FULL_CNT);
                    end
                end
                ST_DONE: begin
                    next_state_s = ST_DONE;
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase

            // Writing the last address fills the buffer and finishes the capture.
            if (wr_s) begin
                count_nxt_s = count_r + ONE_CNT;
                if (count_r == LAST_CNT) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = next_state_s;
                end
            end else begin
                count_nxt_s = count_nxt_s;
            end
        end

        status_nxt_s[31]       = (next_state_s == ST_DONE);
        status_nxt_s[30]       = (next_state_s == ST_ARMED) || (next_state_s == ST_CAPTURE);
        status_nxt_s[ADDR_W:0] = count_nxt_s;
    end

    // Control state, word counter and arm edge detector.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_r <= ST_IDLE;
            count_r <= ZERO_CNT;
            arm_q_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            count_r <= count_nxt_s;
            arm_q_r <= ctrl_in[0];
        end
    end

    // BRAM write port and status register; address/data hold between writes.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            bram_we    <= 1'b0;
            bram_addr  <= {ADDR_W{1'b0}};
            bram_din   <= {DATA_W{1'b0}};
            status_out <= 32'h0000_0000;
        end else begin
            bram_we    <= wr_s;
            status_out <= status_nxt_s;
            if (wr_s) begin
                bram_addr <= count_r[ADDR_W-1:0];
                bram_din  <= din;
            end else begin
                bram_addr <= bram_addr;
                bram_din  <= bram_din;
            end
        end
    end

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Directed self-checking bench for snap_capture_ctrl with a 16-word buffer.
module tb_snap_capture_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic              user_clk;
    logic              user_rst_n;
    logic [31:0]       ctrl_in;
    logic              trig;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic              bram_we;
    logic [31:0]       status_out;

    int n_checks;
    int n_fail;

    snap_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .ctrl_in    (ctrl_in),
        .trig       (trig),
        .din        (din),
        .din_valid  (din_valid),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_we    (bram_we),
        .status_out (status_out)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    typedef struct {
        logic [31:0] ctrl;
        logic        trig;
        logic [31:0] din;
        logic        dv;
        logic        exp_we;
        logic [3:0]  exp_addr;
        logic [31:0] exp_din;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic [31:0] c, input logic t, input logic [31:0] d,
                                input logic v, input logic we, input logic [3:0] a,
                                input logic [31:0] ed, input logic [31:0] st);
        vec_t r;
        r.ctrl = c; r.trig = t; r.din = d; r.dv = v;
        r.exp_we = we; r.exp_addr = a; r.exp_din = ed; r.exp_status = st;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic we, input logic [3:0] addr,
                             input logic [31:0] d, input logic [31:0] st);
        check({tag, ".we"},     {31'd0, bram_we},   {31'd0, we});
        check({tag, ".addr"},   {28'd0, bram_addr}, {28'd0, addr});
        check({tag, ".din"},    bram_din,           d);
        check({tag, ".status"}, status_out,         st);
    endtask

    task automatic drive(input logic [31:0] c, input logic t, input logic [31:0] d, input logic v);
        ctrl_in = c; trig = t; din = d; din_valid = v;
    endtask

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        // ctrl, trig, din, dv | we, addr, din, status
        vecs[0]  = mk(32'h0, 1'b0, 32'hAA, 1'b1, 1'b0, 4'd0, 32'h00, 32'h0000_0000);
        vecs[1]  = mk(32'h1, 1'b1, 32'hBB, 1'b1, 1'b0, 4'd0, 32'h00, 32'h4000_0000);
        vecs[2]  = mk(32'h5, 1'b0, 32'hCC, 1'b1, 1'b0, 4'd0, 32'h00, 32'h8000_0000);
        vecs[3]  = mk(32'h5, 1'b0, 32'hCC, 1'b1, 1'b0, 4'd0, 32'h00, 32'h8000_0000);
        vecs[4]  = mk(32'h0, 1'b1, 32'hCC, 1'b1, 1'b0, 4'd0, 32'h00, 32'h8000_0000);
        vecs[5]  = mk(32'h5, 1'b0, 32'hCC, 1'b0, 1'b0, 4'd0, 32'h00, 32'h4000_0000);
        vecs[6]  = mk(32'h5, 1'b0, 32'hCC, 1'b1, 1'b0, 4'd0, 32'h00, 32'h8000_0000);
        vecs[7]  = mk(32'h0, 1'b0, 32'hCC, 1'b0, 1'b0, 4'd0, 32'h00, 32'h8000_0000);
        vecs[8]  = mk(32'h1, 1'b0, 32'hCC, 1'b1, 1'b0, 4'd0, 32'h00, 32'h4000_0000);
        vecs[9]  = mk(32'h1, 1'b1, 32'h11, 1'b1, 1'b1, 4'd0, 32'h11, 32'h4000_0001);
        vecs[10] = mk(32'h1, 1'b0, 32'h22, 1'b0, 1'b0, 4'd0, 32'h11, 32'h4000_0001);
        vecs[11] = mk(32'h1, 1'b0, 32'h33, 1'b1, 1'b1, 4'd1, 32'h33, 32'h4000_0002);
        vecs[12] = mk(32'h5, 1'b0, 32'h44, 1'b1, 1'b0, 4'd1, 32'h33, 32'h8000_0002);
        vecs[13] = mk(32'h0, 1'b0, 32'h44, 1'b1, 1'b0, 4'd1, 32'h33, 32'h8000_0002);
        vecs[14] = mk(32'h1, 1'b0, 32'h44, 1'b0, 1'b0, 4'd1, 32'h33, 32'h4000_0000);
        vecs[15] = mk(32'h1, 1'b1, 32'h44, 1'b0, 1'b0, 4'd1, 32'h33, 32'h4000_0000);
        vecs[16] = mk(32'h1, 1'b0, 32'h55, 1'b1, 1'b1, 4'd0, 32'h55, 32'h4000_0001);

        drive(32'h0, 1'b0, 32'h0, 1'b0);
        user_rst_n = 1'b0;
        step();
        check_all("reset", 1'b0, 4'd0, 32'h0, 32'h0);
        user_rst_n = 1'b1;

        // Table: idle, arm-wins, stop before trigger, arm+stop, gaps, stop drop
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].ctrl, vecs[i].trig, vecs[i].din, vecs[i].dv);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_addr,
                      vecs[i].exp_din, vecs[i].exp_status);
        end

        // Re-arm mid-capture at count 9
        for (int i = 1; i < 9; i++) begin
            drive(32'h1, 1'b0, 32'h100 + i, 1'b1);
            step();
            check_all($sformatf("fill%0d", i), 1'b1, i[3:0], 32'h100 + i, 32'h4000_0000 | (i + 1));
        end
        drive(32'h0, 1'b0, 32'h0, 1'b0);
        step();
        check("rearm.hold_status", status_out, 32'h4000_0009);
        drive(32'h1, 1'b0, 32'h0, 1'b0);
        step();
        check_all("rearm.armed", 1'b0, 4'd8, 32'h108, 32'h4000_0000);
        drive(32'h1, 1'b1, 32'hABC, 1'b1);
        step();
        check_all("rearm.first", 1'b1, 4'd0, 32'hABC, 32'h4000_0001);

        // Full capture: trig pulse, continuous valid, exactly 16 writes
        drive(32'h0, 1'b0, 32'h0, 1'b0);
        step();
        drive(32'h1, 1'b0, 32'h0, 1'b0);
        step();
        check("full.armed", status_out, 32'h4000_0000);
        for (int i = 0; i < 18; i++) begin
            drive(32'h1, (i == 0), i, 1'b1);
            step();
            if (i < 15)
                check_all($sformatf("full%0d", i), 1'b1, i[3:0], i, 32'h4000_0000 | (i + 1));
            else if (i == 15)
                check_all("full15", 1'b1, 4'd15, 32'd15, 32'h8000_0010);
            else
                check_all($sformatf("full_after%0d", i), 1'b0, 4'd15, 32'd15, 32'h8000_0010);
        end

        // sw_trig with valid every other cycle, stop after 5 writes
        drive(32'h0, 1'b0, 32'h0, 1'b0);
        step();
        drive(32'h3, 1'b0, 32'h0, 1'b0);
        step();
        check("sw.armed", status_out, 32'h4000_0000);
        for (int j = 0; j < 10; j++) begin
            drive(32'h3, 1'b0, 32'h200 + j, (j % 2 == 0));
            step();
            if (j % 2 == 0)
                check_all($sformatf("sw%0d", j), 1'b1, 4'(j / 2), 32'h200 + j, 32'h4000_0000 | (j / 2 + 1));
            else
                check_all($sformatf("sw%0d", j), 1'b0, 4'(j / 2), 32'h200 + j - 1, 32'h4000_0000 | (j / 2 + 1));
        end
        drive(32'h7, 1'b0, 32'h2FF, 1'b1);
        step();
        check_all("sw.stop", 1'b0, 4'd4, 32'h208, 32'h8000_0005);
        step();
        check_all("sw.stop_hold", 1'b0, 4'd4, 32'h208, 32'h8000_0005);

        // Asynchronous reset mid-capture
        drive(32'h0, 1'b0, 32'h0, 1'b0);
        step();
        drive(32'h1, 1'b0, 32'h0, 1'b0);
        step();
        for (int i = 0; i < 7; i++) begin
            drive(32'h1, 1'b1, 32'h300 + i, 1'b1);
            step();
        end
        check_all("pre_reset", 1'b1, 4'd6, 32'h306, 32'h4000_0007);
        #2;
        user_rst_n = 1'b0;
        #1;
        check_all("async_reset", 1'b0, 4'd0, 32'h0, 32'h0);
        step();
        user_rst_n = 1'b1;
        drive(32'h0, 1'b1, 32'h400, 1'b1);
        step();
        check_all("post_reset_idle", 1'b0, 4'd0, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
